// File: rtl/ser_arb_pkg.sv
// Shared types and default parameters for the serial frame arbiter.
package ser_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    localparam int DEF_NREQ    = 2;
    localparam int DEF_DATA_W  = 10;
    localparam int DEF_BIT_DIV = 1;
    localparam int DEF_GAP_CYC = 2;

endpackage

// File: rtl/ser_rr_pick.sv
// Round-robin picker: first asserted valid at or after ptr_i, one-hot out.
module ser_rr_pick
    import ser_arb_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'((int'(ptr_i) + i) % NREQ);
            if (!found && valid_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser_frame_arbiter.sv
// Round-robin arbiter serialising requester frames onto one LSB-first line.
// Define SER_ARB_PARITY_EN to append an even-parity bit to each frame.
module ser_frame_arbiter
    import ser_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BIT_DIV = DEF_BIT_DIV,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ*DATA_W-1:0]   req_data_i,
    output logic [NREQ-1:0]          req_ready_o,
    output logic                     data_o,
    output logic                     ena_o,
    output logic                     busy_o,
    output logic [$clog2(NREQ)-1:0]  gnt_id_o
);

    localparam int IW = $clog2(NREQ);
`ifdef SER_ARB_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int BW = $clog2(FRAME_W);
    localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gnt_q, gnt_d;
    logic [FRAME_W-1:0] sreg_q, sreg_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [DW-1:0]      div_q, div_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               data_q, data_d;
    logic               ena_q, ena_d;

    logic [NREQ-1:0]    pick;
    logic [IW-1:0]      win_idx;
    logic [DATA_W-1:0]  win_data;
    logic [FRAME_W-1:0] frame;
    logic               grant;

    ser_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick)
    );

    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick[k]) begin
                win_idx  = IW'(k);
                win_data = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef SER_ARB_PARITY_EN
    assign frame = {^win_data, win_data};
`else
    assign frame = win_data;
`endif

    // A transfer happens whenever any valid is present in IDLE.
    assign grant       = (state_q == ST_IDLE) && (|req_valid_i) && !rst_i;
    assign req_ready_o = grant ? pick : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sreg_d  = sreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        gap_d   = gap_q;
        data_d  = data_q;
        ena_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                data_d = 1'b0;
                if (grant) begin
                    state_d = ST_SHIFT;
                    sreg_d  = frame;
                    data_d  = frame[0];
                    ena_d   = 1'b1;
                    gnt_d   = win_idx;
                    bit_d   = '0;
                    div_d   = '0;
                    if (win_idx == IW'(NREQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx + 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (div_q == DW'(BIT_DIV - 1)) begin
                    div_d = '0;
                    if (bit_q == BW'(FRAME_W - 1)) begin
                        data_d  = 1'b0;
                        bit_d   = '0;
                        gap_d   = '0;
                        state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sreg_d = sreg_q >> 1;
                        data_d = sreg_q[1];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_GAP: begin
                data_d = 1'b0;
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                data_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            sreg_q  <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            data_q  <= 1'b0;
            ena_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sreg_q  <= sreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            ena_q   <= ena_d;
        end
    end

    assign data_o   = data_q;
    assign ena_o    = ena_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign gnt_id_o = gnt_q;

endmodule
